// File: rtl/mod_mult_rr_scheduler.sv
// Round-robin front end for one shared pipelined Barrett multiplier: arbitration,
// a latency-matched tag pipe for routing results back, and drain-then-load reconfiguration.
module mod_mult_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int LAT  = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*DW-1:0]   i_req_data0,
    input  logic [NREQ*DW-1:0]   i_req_data1,
    output logic [NREQ-1:0]      o_rsp_valid,
    output logic [DW-1:0]        o_rsp_data,
    input  logic                 i_cfg_valid,
    output logic                 o_cfg_ready,
    input  logic [5:0]           i_cfg_k,
    input  logic [2*DW-1:0]      i_cfg_u,
    input  logic [DW-1:0]        i_cfg_mod,
    output logic                 o_mul_en,
    output logic                 o_mul_clr,
    output logic [5:0]           o_mul_k,
    output logic [2*DW-1:0]      o_mul_u,
    output logic [DW-1:0]        o_mul_mod,
    output logic [DW-1:0]        o_mul_data0,
    output logic [DW-1:0]        o_mul_data1,
    input  logic [DW-1:0]        i_mul_data,
    output logic                 o_busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LAT + 2);

    typedef enum logic [1:0] {
        ST_UNCFG = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_LOAD  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_grant_en;
    logic [IW-1:0]          r_ptr;
    logic [IW-1:0]          w_grant_id;
    logic [IW-1:0]          w_idx;
    logic [IW-1:0]          w_ptr_nxt;
    logic [IW:0]            w_sum;
    logic                   w_found;
    logic                   w_accept;
    logic [NREQ-1:0]        w_grant;
    logic [LAT-1:0]         r_tag_v;
    logic [LAT-1:0][IW-1:0] r_tag_id;
    logic [CW-1:0]          r_cnt;
    logic [NREQ-1:0]        r_rsp_valid;
    logic [DW-1:0]          r_rsp_data;
    logic                   r_cfg_ready;
    logic                   r_mul_clr;
    logic [5:0]             r_mul_k;
    logic [2*DW-1:0]        r_mul_u;
    logic [DW-1:0]          r_mul_mod;
    logic [DW-1:0]          r_mul_data0;
    logic [DW-1:0]          r_mul_data1;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_UNCFG;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a pending config request blocks new grants immediately
    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        case (r_state)
            ST_UNCFG: w_state_nxt = i_cfg_valid ? ST_LOAD : ST_UNCFG;
            ST_RUN: begin
                w_grant_en  = ~i_cfg_valid;
                w_state_nxt = i_cfg_valid ? ST_DRAIN : ST_RUN;
            end
            ST_DRAIN: w_state_nxt = (r_cnt == {CW{1'b0}}) ? ST_LOAD : ST_DRAIN;
            ST_LOAD:  w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_UNCFG;
        endcase
    end

    // Round-robin search starting at the pointer, wrapping past NREQ-1
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        w_sum      = '0;
        w_idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            w_idx = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : IW'(w_sum);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found    = 1'b1;
                w_grant_id = w_idx;
            end else begin
                w_found    = w_found;
            end
        end
        w_accept  = w_found & w_grant_en;
        w_grant   = w_accept ? (NREQ'(1) << w_grant_id) : {NREQ{1'b0}};
        w_ptr_nxt = (w_grant_id == IW'(NREQ - 1)) ? {IW{1'b0}} : w_grant_id + IW'(1);
    end

    // Pointer and operand registers advance only on an accept
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr       <= '0;
            r_mul_data0 <= '0;
            r_mul_data1 <= '0;
        end else if (w_accept) begin
            r_ptr       <= w_ptr_nxt;
            r_mul_data0 <= i_req_data0[w_grant_id*DW +: DW];
            r_mul_data1 <= i_req_data1[w_grant_id*DW +: DW];
        end else begin
            r_ptr       <= r_ptr;
            r_mul_data0 <= r_mul_data0;
            r_mul_data1 <= r_mul_data1;
        end
    end

    // Tag pipe: the last stage lines up with i_mul_data for the same operation
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tag_v     <= '0;
            r_tag_id    <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_tag_v     <= {r_tag_v[LAT-2:0], w_accept};
            r_tag_id    <= {r_tag_id[LAT-2:0], w_grant_id};
            r_rsp_valid <= r_tag_v[LAT-1] ? (NREQ'(1) << r_tag_id[LAT-1]) : {NREQ{1'b0}};
            if (r_tag_v[LAT-1]) begin
                r_rsp_data <= i_mul_data;
            end else begin
                r_rsp_data <= r_rsp_data;
            end
        end
    end

    // In-flight counter: accept and retire in the same cycle cancel out
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else begin
            case ({w_accept, r_tag_v[LAT-1]})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Config constants are captured on entry to LOAD so they are stable while oCfgReady is high
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cfg_ready <= 1'b0;
            r_mul_clr   <= 1'b1;
            r_mul_k     <= '0;
            r_mul_u     <= '0;
            r_mul_mod   <= '0;
        end else begin
            r_cfg_ready <= (w_state_nxt == ST_LOAD);
            r_mul_clr   <= (w_state_nxt == ST_LOAD);
            if (w_state_nxt == ST_LOAD) begin
                r_mul_k   <= i_cfg_k;
                r_mul_u   <= i_cfg_u;
                r_mul_mod <= i_cfg_mod;
            end else begin
                r_mul_k   <= r_mul_k;
                r_mul_u   <= r_mul_u;
                r_mul_mod <= r_mul_mod;
            end
        end
    end

    assign o_req_ready = w_grant;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_cfg_ready = r_cfg_ready;
    assign o_mul_en    = 1'b1;
    assign o_mul_clr   = r_mul_clr;
    assign o_mul_k     = r_mul_k;
    assign o_mul_u     = r_mul_u;
    assign o_mul_mod   = r_mul_mod;
    assign o_mul_data0 = r_mul_data0;
    assign o_mul_data1 = r_mul_data1;
    assign o_busy      = (r_cnt != {CW{1'b0}});

endmodule

// File: tb/tb_mod_mult_rr_scheduler.sv
// Randomized bench for mod_mult_rr_scheduler with a latency-accurate multiplier stand-in
// and a scoreboard of expected (A*B)%Mod results keyed by due cycle and requester.
`timescale 1ns/1ps
module tb_mod_mult_rr_scheduler;
    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int LAT  = 6;

    logic                 clk = 1'b0;
    logic                 i_rst;
    logic [NREQ-1:0]      i_req_valid;
    logic [NREQ-1:0]      o_req_ready;
    logic [NREQ*DW-1:0]   i_req_data0;
    logic [NREQ*DW-1:0]   i_req_data1;
    logic [NREQ-1:0]      o_rsp_valid;
    logic [DW-1:0]        o_rsp_data;
    logic                 i_cfg_valid;
    logic                 o_cfg_ready;
    logic [5:0]           i_cfg_k;
    logic [2*DW-1:0]      i_cfg_u;
    logic [DW-1:0]        i_cfg_mod;
    logic                 o_mul_en;
    logic                 o_mul_clr;
    logic [5:0]           o_mul_k;
    logic [2*DW-1:0]      o_mul_u;
    logic [DW-1:0]        o_mul_mod;
    logic [DW-1:0]        o_mul_data0;
    logic [DW-1:0]        o_mul_data1;
    logic [DW-1:0]        i_mul_data;
    logic                 o_busy;

    mod_mult_rr_scheduler #(.NREQ(NREQ), .DW(DW), .LAT(LAT)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_data0(i_req_data0), .i_req_data1(i_req_data1),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
        .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
        .i_cfg_k(i_cfg_k), .i_cfg_u(i_cfg_u), .i_cfg_mod(i_cfg_mod),
        .o_mul_en(o_mul_en), .o_mul_clr(o_mul_clr),
        .o_mul_k(o_mul_k), .o_mul_u(o_mul_u), .o_mul_mod(o_mul_mod),
        .o_mul_data0(o_mul_data0), .o_mul_data1(o_mul_data1),
        .i_mul_data(i_mul_data), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc   = 0;
    int          n_ops = 0;
    int          vp [NREQ];
    logic        m_run = 1'b0;
    logic [DW-1:0] m_mod = '0;
    logic [NREQ-1:0] acc_mask = '0;

    typedef struct {
        int unsigned   due;
        int            id;
        logic [DW-1:0] d;
    } exp_t;
    exp_t sb [$];

    function automatic logic [DW-1:0] modmul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] m);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        if (m == '0) return '0;
        return DW'(p % {32'd0, m});
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Multiplier stand-in: operands registered at edge E yield a result sampled at edge E+LAT
    logic [DW-1:0] mp [LAT-1];
    always @(posedge clk) begin
        mp[0] <= modmul(o_mul_data0, o_mul_data1, o_mul_mod);
        for (int k = 1; k < LAT - 1; k++) mp[k] <= mp[k-1];
    end
    assign i_mul_data = mp[LAT-2];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: round-robin grant rule, in-flight set and timed result scoreboard
    initial begin
        logic [NREQ-1:0] exp_v;
        logic [NREQ-1:0] exp_g;
        logic [DW-1:0]   exp_d;
        int              m_ptr;
        int              gid;
        int              idx;
        exp_t            e;
        m_ptr = 0;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                sb.delete();
                m_ptr    = 0;
                acc_mask = '0;
            end else begin
                exp_v = '0;
                exp_d = '0;
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    exp_v[sb[0].id] = 1'b1;
                    exp_d = sb[0].d;
                    void'(sb.pop_front());
                end
                check_eq("rsp_valid", o_rsp_valid, exp_v);
                if (exp_v != '0) check_eq("rsp_data", o_rsp_data, exp_d);
                check_eq("busy", o_busy, sb.size() != 0);
                exp_g = '0;
                gid   = -1;
                if (m_run && !i_cfg_valid) begin
                    for (int k = 0; k < NREQ; k++) begin
                        idx = (m_ptr + k) % NREQ;
                        if (gid < 0 && i_req_valid[idx]) gid = idx;
                    end
                end
                if (gid >= 0) exp_g[gid] = 1'b1;
                check_eq("grant", o_req_ready, exp_g);
                acc_mask = i_req_valid & o_req_ready;
                if (gid >= 0) begin
                    e.due = cyc + 1 + LAT;
                    e.id  = gid;
                    e.d   = modmul(i_req_data0[gid*DW +: DW], i_req_data1[gid*DW +: DW], m_mod);
                    sb.push_back(e);
                    m_ptr = (gid + 1) % NREQ;
                    n_ops++;
                end
            end
        end
    end

    function automatic logic [DW-1:0] rnd_op();
        if (m_mod > 1) return $urandom % m_mod;
        return $urandom;
    endfunction

    // Advance one clock; requesters hold until accepted, then may re-request with new operands
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_mask[i] || !i_req_valid[i]) begin
                i_req_valid[i] = ($urandom_range(99) < vp[i]);
                i_req_data0[i*DW +: DW] = rnd_op();
                i_req_data1[i*DW +: DW] = rnd_op();
            end
        end
    endtask

    task automatic do_cfg(input logic [5:0] k, input logic [63:0] u, input logic [DW-1:0] m);
        bit got;
        got = 1'b0;
        i_cfg_k     = k;
        i_cfg_u     = u;
        i_cfg_mod   = m;
        i_cfg_valid = 1'b1;
        m_run       = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (o_cfg_ready) got = 1'b1;
            else tick();
        end
        check_eq("cfg_ready_seen", got, 1'b1);
        check_eq("cfg_drained", o_busy, 1'b0);
        check_eq("cfg_clr", o_mul_clr, 1'b1);
        check_eq("cfg_k", o_mul_k, k);
        check_eq("cfg_u", o_mul_u, u);
        check_eq("cfg_mod", o_mul_mod, m);
        tick();
        i_cfg_valid = 1'b0;
        m_mod       = m;
        m_run       = 1'b1;
        @(negedge clk);
        check_eq("cfg_pulse_end", o_cfg_ready, 1'b0);
        check_eq("clr_run", o_mul_clr, 1'b0);
    endtask

    task automatic cfg_for(input logic [DW-1:0] m);
        logic [5:0]   k;
        logic [127:0] u;
        k = 6'd0;
        for (int b = 0; b < DW; b++) if (m[b]) k = 6'(b + 1);
        u = (128'd1 << (2 * k)) / {96'd0, m};
        do_cfg(k, u[63:0], m);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

    initial begin
        int bad;
        int t0;
        bit got;
        int guard;
        int target;
        logic [63:0] exp2;
        logic [DW-1:0] rm;

        i_rst = 1'b1;
        i_req_valid = '0;
        i_req_data0 = '0;
        i_req_data1 = '0;
        i_cfg_valid = 1'b0;
        i_cfg_k = '0;
        i_cfg_u = '0;
        i_cfg_mod = '0;
        for (int i = 0; i < NREQ; i++) vp[i] = 100;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", o_req_ready, '0);
        check_eq("rst_rsp_valid", o_rsp_valid, '0);
        check_eq("rst_rsp_data", o_rsp_data, '0);
        check_eq("rst_cfg_ready", o_cfg_ready, 1'b0);
        check_eq("rst_mul_en", o_mul_en, 1'b1);
        check_eq("rst_mul_clr", o_mul_clr, 1'b1);
        check_eq("rst_mul_k", o_mul_k, '0);
        check_eq("rst_mul_u", o_mul_u, '0);
        check_eq("rst_mul_mod", o_mul_mod, '0);
        check_eq("rst_mul_data0", o_mul_data0, '0);
        check_eq("rst_busy", o_busy, 1'b0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;

        // Unconfigured: every requester asks, nobody may be granted
        bad = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            @(negedge clk);
            if (o_req_ready != '0) bad++;
        end
        check_eq("t1_no_grant", bad, 0);
        check_eq("t1_clr_low", o_mul_clr, 1'b0);
        tick();
        do_cfg(6'd32, 64'h0000_0001_0000_0001, 32'hFFFF_FFFF);

        // Pointer starts at 0 with all requesters asking
        for (int j = 0; j < 8; j++) begin
            check_eq("t3_rr_order", o_req_ready, NREQ'(1) << (j % NREQ));
            tick();
            @(negedge clk);
        end

        // Drain, reconfigure to Mod=7681, then a single operation from requester 0
        for (int i = 0; i < NREQ; i++) vp[i] = 0;
        repeat (12) tick();
        do_cfg(6'd13, 64'd8736, 32'd7681);
        tick();
        i_req_valid[0] = 1'b1;
        i_req_data0[0 +: DW] = 32'd1467;
        i_req_data1[0 +: DW] = 32'd2489;
        @(negedge clk);
        check_eq("t2_grant", o_req_ready, 4'b0001);
        t0 = cyc;
        exp2 = (64'd1467 * 64'd2489) % 64'd7681;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            tick();
            @(negedge clk);
            if (o_rsp_valid != '0) begin
                got = 1'b1;
                check_eq("t2_latency", cyc - t0, LAT + 1);
                check_eq("t2_rsp_valid", o_rsp_valid, 4'b0001);
                check_eq("t2_rsp_data", o_rsp_data, exp2);
            end
        end
        check_eq("t2_rsp_seen", got, 1'b1);

        // Requester 1 alone moves the pointer to 2; then requesters 1 and 3 compete
        vp[1] = 100;
        repeat (3) tick();
        vp[3] = 100;
        tick();
        @(negedge clk);
        check_eq("t4_first_3", o_req_ready, 4'b1000);
        tick();
        @(negedge clk);
        check_eq("t4_then_1", o_req_ready, 4'b0010);
        vp[3] = 0;
        tick();
        @(negedge clk);
        check_eq("t4_last_3", o_req_ready, 4'b1000);
        for (int j = 0; j < 4; j++) begin
            tick();
            @(negedge clk);
            check_eq("t4_only_1", o_req_ready, 4'b0010);
        end

        // Reconfigure in the middle of a busy stream
        for (int i = 0; i < NREQ; i++) vp[i] = 80;
        repeat (30) tick();
        cfg_for(32'd65521);
        repeat (40) tick();

        // One-cycle reset with operations in flight
        for (int i = 0; i < NREQ; i++) vp[i] = 100;
        repeat (12) tick();
        @(negedge clk);
        check_eq("t6_busy_before", o_busy, 1'b1);
        tick();
        i_rst = 1'b1;
        m_run = 1'b0;
        tick();
        i_rst = 1'b0;
        m_mod = '0;
        @(negedge clk);
        check_eq("t6_busy_after", o_busy, 1'b0);
        check_eq("t6_mod_lost", o_mul_mod, '0);
        check_eq("t6_no_grant", o_req_ready, '0);
        bad = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            @(negedge clk);
            if (o_rsp_valid != '0) bad++;
        end
        check_eq("t6_no_stale_rsp", bad, 0);
        tick();
        cfg_for(32'd1000003);

        // Random traffic with occasional reconfiguration
        target = n_ops + 10000;
        guard  = 0;
        while (n_ops < target && guard < 60000) begin
            for (int i = 0; i < NREQ; i++) vp[i] = $urandom_range(100);
            repeat (100) tick();
            guard += 100;
            if ($urandom_range(7) == 0) begin
                rm = $urandom;
                if (rm < 2) rm = 32'd2;
                cfg_for(rm);
            end
        end
        check_eq("random_ops_done", n_ops >= target, 1'b1);
        for (int i = 0; i < NREQ; i++) vp[i] = 0;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
